// File: rtl/dmem_rr_arbiter_if.sv
// dmem_rr_arbiter_if
// Bundles the four requester-facing signals and the single-port memory
// signals of the data-memory round-robin arbiter.
//   req/wr_en/lock      per-requester access request, write select, hold-bank
//   addr_in/wdata_in    packed per-requester address and write data
//   gnt/rvalid/rdata    one-hot grant, one-hot read-valid, shared read data
//   memEn/memWrEn       memory enable / write enable
//   addr_out/d_out      memory address / write data
//   d_in                memory read data (one cycle after a read command)
// Modports: slave = arbiter side, master = requesters plus memory model side.
interface dmem_rr_arbiter_if #(
  parameter int DATA_WIDTH         = 64,
  parameter int DMEM_ADDRESS_WIDTH = 32
);
  logic [3:0]                      req;
  logic [3:0]                      wr_en;
  logic [3:0]                      lock;
  logic [4*DMEM_ADDRESS_WIDTH-1:0] addr_in;
  logic [4*DATA_WIDTH-1:0]         wdata_in;
  logic [3:0]                      gnt;
  logic [3:0]                      rvalid;
  logic [DATA_WIDTH-1:0]           rdata;
  logic                            memEn;
  logic                            memWrEn;
  logic [DMEM_ADDRESS_WIDTH-1:0]   addr_out;
  logic [DATA_WIDTH-1:0]           d_out;
  logic [DATA_WIDTH-1:0]           d_in;

  modport slave (
    input  req, wr_en, lock, addr_in, wdata_in, d_in,
    output gnt, rvalid, rdata, memEn, memWrEn, addr_out, d_out
  );

  modport master (
    output req, wr_en, lock, addr_in, wdata_in, d_in,
    input  gnt, rvalid, rdata, memEn, memWrEn, addr_out, d_out
  );
endinterface

// File: rtl/dmem_rr_arbiter.sv
// dmem_rr_arbiter
// Shares one single-port data memory bank between four requesters with
// round-robin priority and a bounded lock for back-to-back accesses.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-low
//   bus    dmem_rr_arbiter_if.slave: requester handshake and memory port
module dmem_rr_arbiter #(
  parameter int DATA_WIDTH         = 64,
  parameter int DMEM_ADDRESS_WIDTH = 32,
  parameter int LOCK_MAX           = 4
) (
  input  logic              clk,
  input  logic              reset,
  dmem_rr_arbiter_if.slave  bus
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam int AW    = DMEM_ADDRESS_WIDTH;
  localparam int DW    = DATA_WIDTH;

  logic [1:0]       ptr;
  logic [CNT_W-1:0] lock_cnt;
  logic [3:0]       rd_pend;

  logic [1:0]       gnt_idx;
  logic [1:0]       cand;
  logic             gnt_any;
  logic             gnt_vld;
  logic [3:0]       gnt;

  // Priority search starting at ptr and wrapping 3 -> 0; the first
  // requesting index wins.
  always_comb begin
    gnt_idx = ptr;
    gnt_any = 1'b0;
    cand    = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!gnt_any && bus.req[cand]) begin
        gnt_any = 1'b1;
        gnt_idx = cand;
      end
    end
  end

  // A low reset suppresses every grant, so no command reaches memory.
  assign gnt_vld = gnt_any & reset;

  always_comb begin
    gnt = 4'b0000;
    if (gnt_vld) gnt[gnt_idx] = 1'b1;
  end

  assign bus.gnt      = gnt;
  assign bus.memEn    = gnt_vld;
  assign bus.memWrEn  = gnt_vld & bus.wr_en[gnt_idx];
  assign bus.addr_out = gnt_vld ? bus.addr_in[gnt_idx*AW +: AW]  : '0;
  assign bus.d_out    = gnt_vld ? bus.wdata_in[gnt_idx*DW +: DW] : '0;

  assign bus.rvalid = rd_pend;
  assign bus.rdata  = bus.d_in;

  // A locking winner keeps priority until it has held the bank LOCK_MAX
  // consecutive cycles; then ptr moves past it so everyone else gets a turn.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr      <= 2'd0;
      lock_cnt <= '0;
      rd_pend  <= 4'b0000;
    end else begin
      rd_pend <= gnt & ~bus.wr_en;
      if (!gnt_vld) begin
        lock_cnt <= '0;
      end else if (bus.lock[gnt_idx] && (int'(lock_cnt) < LOCK_MAX - 1)) begin
        ptr      <= gnt_idx;
        lock_cnt <= lock_cnt + 1'b1;
      end else begin
        ptr      <= gnt_idx + 2'd1;
        lock_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// tb_dmem_rr_arbiter
// Directed, table-driven bench for dmem_rr_arbiter. Each table row is one
// clock cycle: inputs are driven at the falling edge and outputs are
// compared shortly after, away from the rising edge. A second instance with
// LOCK_MAX=1 follows the same inputs and is checked in one hand sequence.
module tb_dmem_rr_arbiter;

  localparam int DW = 64;
  localparam int AW = 32;

  logic clk;
  logic reset;

  int total;
  int bad;

  dmem_rr_arbiter_if #(.DATA_WIDTH(DW), .DMEM_ADDRESS_WIDTH(AW)) bus  ();
  dmem_rr_arbiter_if #(.DATA_WIDTH(DW), .DMEM_ADDRESS_WIDTH(AW)) bus1 ();

  dmem_rr_arbiter #(.DATA_WIDTH(DW), .DMEM_ADDRESS_WIDTH(AW), .LOCK_MAX(4)) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  dmem_rr_arbiter #(.DATA_WIDTH(DW), .DMEM_ADDRESS_WIDTH(AW), .LOCK_MAX(1)) u_dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus1.slave)
  );

  assign bus1.req      = bus.req;
  assign bus1.wr_en    = bus.wr_en;
  assign bus1.lock     = bus.lock;
  assign bus1.addr_in  = bus.addr_in;
  assign bus1.wdata_in = bus.wdata_in;
  assign bus1.d_in     = bus.d_in;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [3:0] req;
    logic [3:0] wr;
    logic [3:0] lk;
    logic [3:0] exp_gnt;
    logic [3:0] exp_rv;
  } vec_t;

  vec_t vecs[$];

  // Fixed per-requester addresses and write data; requester 2 sits at 0x40.
  function automatic logic [AW-1:0] req_addr(input int i);
    case (i)
      0:       return 32'h0000_0010;
      1:       return 32'h0000_0020;
      2:       return 32'h0000_0040;
      default: return 32'h0000_0080;
    endcase
  endfunction

  function automatic logic [DW-1:0] req_wdata(input int i);
    return 64'h5A5A_0000_0000_00A0 + 64'(i);
  endfunction

  function automatic logic [AW-1:0] exp_addr(input logic [3:0] g);
    logic [AW-1:0] a;
    a = '0;
    for (int i = 0; i < 4; i++) if (g[i]) a = req_addr(i);
    return a;
  endfunction

  function automatic logic [DW-1:0] exp_wdata(input logic [3:0] g);
    logic [DW-1:0] d;
    d = '0;
    for (int i = 0; i < 4; i++) if (g[i]) d = req_wdata(i);
    return d;
  endfunction

  task automatic check_output(input string name, input logic [DW-1:0] actual,
                              input logic [DW-1:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input logic rst_n, input logic [3:0] req,
                                input logic [3:0] wr, input logic [3:0] lk,
                                input logic [DW-1:0] din);
    reset     = rst_n;
    bus.req   = req;
    bus.wr_en = wr;
    bus.lock  = lk;
    bus.d_in  = din;
  endtask

  task automatic check_row(input int r, input vec_t v);
    string tag;
    tag = $sformatf("row%0d", r);
    check_output({tag, " gnt"},      64'(bus.gnt),      64'(v.exp_gnt));
    check_output({tag, " memEn"},    64'(bus.memEn),    64'(|v.exp_gnt));
    check_output({tag, " memWrEn"},  64'(bus.memWrEn),  64'(|(v.exp_gnt & v.wr)));
    check_output({tag, " addr_out"}, 64'(bus.addr_out), 64'(exp_addr(v.exp_gnt)));
    check_output({tag, " d_out"},    bus.d_out,         exp_wdata(v.exp_gnt));
    check_output({tag, " rvalid"},   64'(bus.rvalid),   64'(v.exp_rv));
    if (v.exp_rv != 4'b0000)
      check_output({tag, " rdata"}, bus.rdata, 64'hDEAD + 64'(r));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 4; i++) begin
      bus.addr_in[i*AW +: AW]  = req_addr(i);
      bus.wdata_in[i*DW +: DW] = req_wdata(i);
    end

    // Fields: rst_n, req, wr_en, lock, expected gnt, expected rvalid.
    // Single read by requester 2, then memory returns data.
    vecs.push_back('{1'b1, 4'b0100, 4'b0000, 4'b0000, 4'b0100, 4'b0000});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100});
    // Reset to bring ptr to 0, then full contention with mixed reads/writes.
    vecs.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1010, 4'b0000, 4'b0001, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1010, 4'b0000, 4'b0010, 4'b0001});
    vecs.push_back('{1'b1, 4'b1111, 4'b1010, 4'b0000, 4'b0100, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1010, 4'b0000, 4'b1000, 4'b0100});
    vecs.push_back('{1'b1, 4'b1111, 4'b1010, 4'b0000, 4'b0001, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1010, 4'b0000, 4'b0010, 4'b0001});
    vecs.push_back('{1'b1, 4'b1111, 4'b1010, 4'b0000, 4'b0100, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1010, 4'b0000, 4'b1000, 4'b0100});
    // Move ptr to 1, then requester 1 locks: 4 grants, then 2, 3, 0, 1.
    vecs.push_back('{1'b1, 4'b0001, 4'b1111, 4'b0000, 4'b0001, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0100, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b1000, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0001, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'b0000});
    // Second locked grant, then requester 1 drops req: 2 wins, not 0.
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'b0000});
    vecs.push_back('{1'b1, 4'b1101, 4'b1111, 4'b0000, 4'b0100, 4'b0000});
    // Fresh lock by 1 lasts a full 4 grants, so the counter was cleared.
    vecs.push_back('{1'b1, 4'b0010, 4'b1111, 4'b0010, 4'b0010, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0010, 4'b0010, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b1111, 4'b0000, 4'b0100, 4'b0000});
    // Wrap/skip: grant 3, then only req[1]; ptr lands on 2.
    vecs.push_back('{1'b1, 4'b1000, 4'b0000, 4'b0000, 4'b1000, 4'b0000});
    vecs.push_back('{1'b1, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b1000});
    vecs.push_back('{1'b1, 4'b0101, 4'b0000, 4'b0000, 4'b0100, 4'b0010});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0100});
    // Reset right after a read grant: pending read dropped, ptr back to 0.
    vecs.push_back('{1'b1, 4'b0110, 4'b0000, 4'b0000, 4'b0010, 4'b0000});
    vecs.push_back('{1'b0, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0010});
    vecs.push_back('{1'b0, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000});
    vecs.push_back('{1'b1, 4'b1111, 4'b0000, 4'b0000, 4'b0001, 4'b0000});
    vecs.push_back('{1'b1, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0001});

    // Initial reset with every requester asking: nothing may be granted.
    apply_stimulus(1'b0, 4'b1111, 4'b0000, 4'b0000, '0);
    @(negedge clk);
    #1;
    check_output("reset gnt",   64'(bus.gnt),    64'h0);
    check_output("reset memEn", 64'(bus.memEn),  64'h0);
    @(negedge clk);
    #1;
    check_output("reset rvalid", 64'(bus.rvalid), 64'h0);

    foreach (vecs[r]) begin
      @(negedge clk);
      apply_stimulus(vecs[r].rst_n, vecs[r].req, vecs[r].wr, vecs[r].lk,
                     64'hDEAD + 64'(r));
      #1;
      check_row(r, vecs[r]);
    end

    // Reset dropped in the same cycle as a read grant to requester 0.
    @(negedge clk);
    apply_stimulus(1'b1, 4'b0001, 4'b0000, 4'b0000, '0);
    #1;
    check_output("midrd gnt before", 64'(bus.gnt), 64'(4'b0001));
    reset = 1'b0;
    #1;
    check_output("midrd gnt forced",   64'(bus.gnt),     64'h0);
    check_output("midrd memEn forced", 64'(bus.memEn),   64'h0);
    check_output("midrd memWrEn",      64'(bus.memWrEn), 64'h0);
    @(negedge clk);
    apply_stimulus(1'b0, 4'b1111, 4'b0000, 4'b0000, '0);
    #1;
    check_output("midrd rvalid dropped", 64'(bus.rvalid), 64'h0);
    check_output("midrd gnt in reset",   64'(bus.gnt),    64'h0);
    @(negedge clk);
    apply_stimulus(1'b1, 4'b1111, 4'b1111, 4'b1111, '0);
    #1;
    check_output("midrd first gnt", 64'(bus.gnt), 64'(4'b0001));

    // Everyone locking: LOCK_MAX=4 keeps 0 for four cycles, LOCK_MAX=1 rotates.
    // The previous step already granted 0 once in both instances.
    begin
      logic [3:0] exp4 [5];
      logic [3:0] exp1 [5];
      exp4 = '{4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0010};
      exp1 = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010};
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        #1;
        check_output($sformatf("lockall max4 c%0d", c), 64'(bus.gnt),  64'(exp4[c]));
        check_output($sformatf("lockall max1 c%0d", c), 64'(bus1.gnt), 64'(exp1[c]));
      end
    end

    @(negedge clk);
    apply_stimulus(1'b1, 4'b0000, 4'b0000, 4'b0000, '0);
    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
